// File: rtl/mem_sweep_reader_if.sv
// Memory read port plus valid/ready word stream between mem_sweep_reader and its peers.
interface mem_sweep_reader_if #(
    parameter int unsigned NBITS_ADDR = 2,
    parameter int unsigned NBITS_DATA = 4
) ();
    logic                  mem_rd_en;
    logic [NBITS_ADDR-1:0] mem_addr;
    logic [NBITS_DATA-1:0] mem_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NBITS_ADDR-1:0] out_addr;
    logic [NBITS_DATA-1:0] out_data;

    modport master (
        output mem_rd_en, mem_addr, out_valid, out_addr, out_data,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_addr, out_data,
        output mem_data, out_ready
    );
endinterface

// File: rtl/mem_sweep_reader.sv
// Reads one word or sweeps the whole memory (wrapping) and streams {addr, data} out.
// Optional checksum accumulator: define MEM_SWEEP_READER_CHECKSUM_EN.
module mem_sweep_reader #(
    parameter int unsigned NBITS_ADDR = 2,
    parameter int unsigned NBITS_DATA = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  single,
    input  logic [NBITS_ADDR-1:0] start_addr,
    mem_sweep_reader_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic [NBITS_DATA-1:0] checksum
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [NBITS_ADDR-1:0] LAST_CNT = '1;

    state_t                state_q, state_nxt;
    logic                  single_q;
    logic [NBITS_ADDR-1:0] cur_addr_q;
    logic [NBITS_ADDR-1:0] cnt_q;
    logic                  rd_en_q;
    logic                  out_valid_q;
    logic [NBITS_ADDR-1:0] out_addr_q;
    logic [NBITS_DATA-1:0] out_data_q;
    logic                  busy_q;
    logic                  done_q;

    logic start_c, capture_c, accept_c, last_c, advance_c;

    // State register
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:  if (start_c) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_HOLD;
            S_HOLD:  if (accept_c) state_nxt = last_c ? S_DONE : S_REQ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        start_c   = 1'b0;
        capture_c = 1'b0;
        accept_c  = 1'b0;
        last_c    = single_q || (cnt_q == LAST_CNT);
        unique case (state_q)
            S_IDLE:  start_c   = start;
            S_WAIT:  capture_c = 1'b1;
            S_HOLD:  accept_c  = bus.out_ready;
            default: ;
        endcase
        advance_c = accept_c && !last_c;
    end

    // Registered outputs follow the upcoming state so they line up with it
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            single_q    <= 1'b0;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            rd_en_q     <= (state_nxt == S_REQ);
            out_valid_q <= (state_nxt == S_HOLD);
            busy_q      <= (state_nxt != S_IDLE);
            done_q      <= (state_nxt == S_DONE);
            if (start_c) begin
                single_q   <= single;
                cur_addr_q <= start_addr;
                cnt_q      <= '0;
            end
            if (capture_c) begin
                out_data_q <= bus.mem_data;
                out_addr_q <= cur_addr_q;
            end
            if (advance_c) begin
                cur_addr_q <= cur_addr_q + NBITS_ADDR'(1);
                cnt_q      <= cnt_q + NBITS_ADDR'(1);
            end
        end
    end

`ifdef MEM_SWEEP_READER_CHECKSUM_EN
    logic [NBITS_DATA-1:0] checksum_q;

    // Modular sum of accepted words; held after the transaction ends
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)      checksum_q <= '0;
        else if (start_c)  checksum_q <= '0;
        else if (accept_c) checksum_q <= checksum_q + out_data_q;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = cur_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mem_sweep_reader.sv
// Directed table-driven bench for mem_sweep_reader against a 4-entry sync-read memory.
module tb_mem_sweep_reader;
    localparam int unsigned NA = 2;
    localparam int unsigned ND = 4;
`ifdef MEM_SWEEP_READER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic          clk_2 = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          single = 1'b0;
    logic [NA-1:0] start_addr = '0;
    logic          busy, done;
    logic [ND-1:0] checksum;

    int n_vec = 0;
    int n_err = 0;

    mem_sweep_reader_if #(.NBITS_ADDR(NA), .NBITS_DATA(ND)) bus ();

    mem_sweep_reader #(.NBITS_ADDR(NA), .NBITS_DATA(ND)) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .start      (start),
        .single     (single),
        .start_addr (start_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [ND-1:0] mem_word(input logic [NA-1:0] a);
        case (a)
            2'd0:    return 4'hA;
            2'd1:    return 4'h5;
            2'd2:    return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    // Memory model: synchronous read, latency 1
    always @(posedge clk_2) begin
        if (bus.mem_rd_en) bus.mem_data <= mem_word(bus.mem_addr);
    end

    typedef struct {
        bit            single;
        logic [NA-1:0] addr;
        int            stall;
        int            poke;
        int            n;
        logic [NA-1:0] exp_addr[4];
        logic [ND-1:0] exp_data[4];
        logic [ND-1:0] cks;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, n_xfer = 0, n_done = 0, n_rd = 0, first_valid = 0;
        int n_busy = 0, done_cyc = 0, stall = v.stall, bad = 0;
        bit seen_done = 1'b0, was_stalled = 1'b0;
        logic [NA-1:0] first_rd = '1;
        logic [NA-1:0] hold_a = '0;
        logic [ND-1:0] hold_d = '0;
        logic [NA-1:0] got_a[4];
        logic [ND-1:0] got_d[4];
        for (int i = 0; i < 4; i++) begin
            got_a[i] = '0;
            got_d[i] = '0;
        end
        bus.out_ready = 1'b1;
        single = v.single;
        start_addr = v.addr;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 80) begin
            cyc++;
            if (v.poke == cyc) begin
                start = 1'b1;
                start_addr = 2'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) n_busy++;
            if (bus.mem_rd_en) begin
                if (n_rd == 0) first_rd = bus.mem_addr;
                n_rd++;
                if (bus.out_valid) bad++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (bus.out_valid) bad++;
                seen_done = 1'b1;
            end
            if (bus.out_valid) begin
                if (first_valid == 0) first_valid = cyc;
                if (was_stalled && (bus.out_addr != hold_a || bus.out_data != hold_d)) bad++;
                if (stall > 0) begin
                    bus.out_ready = 1'b0;
                    stall--;
                    was_stalled = 1'b1;
                    hold_a = bus.out_addr;
                    hold_d = bus.out_data;
                end else begin
                    bus.out_ready = 1'b1;
                    if (n_xfer < 4) begin
                        got_a[n_xfer] = bus.out_addr;
                        got_d[n_xfer] = bus.out_data;
                    end
                    n_xfer++;
                    was_stalled = 1'b0;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        chk($sformatf("v%0d_xfer_count", idx), n_xfer, v.n);
        for (int i = 0; i < v.n; i++) begin
            chk($sformatf("v%0d_xfer%0d_addr", idx, i), int'(got_a[i]), int'(v.exp_addr[i]));
            chk($sformatf("v%0d_xfer%0d_data", idx, i), int'(got_d[i]), int'(v.exp_data[i]));
        end
        chk($sformatf("v%0d_done_pulses", idx), n_done, 1);
        chk($sformatf("v%0d_rd_strobes", idx), n_rd, v.n);
        chk($sformatf("v%0d_first_rd_addr", idx), int'(first_rd), int'(v.addr));
        chk($sformatf("v%0d_first_valid_cyc", idx), first_valid, 3);
        chk($sformatf("v%0d_busy_cycles", idx), n_busy, 3 * v.n + v.stall + 1);
        chk($sformatf("v%0d_done_cyc", idx), done_cyc, 3 * v.n + v.stall + 1);
        chk($sformatf("v%0d_protocol", idx), bad, 0);
        chk($sformatf("v%0d_checksum", idx), int'(checksum), CKS_EN ? int'(v.cks) : 0);
        chk($sformatf("v%0d_idle_after", idx), int'({busy, bus.out_valid, done, bus.mem_rd_en}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int holds;
        vt[0] = '{single: 1'b1, addr: 2'd2, stall: 0, poke: 0, n: 1,
                  exp_addr: '{2'd2, 2'd0, 2'd0, 2'd0},
                  exp_data: '{4'h3, 4'h0, 4'h0, 4'h0}, cks: 4'h3};
        vt[1] = '{single: 1'b0, addr: 2'd2, stall: 0, poke: 0, n: 4,
                  exp_addr: '{2'd2, 2'd3, 2'd0, 2'd1},
                  exp_data: '{4'h3, 4'hF, 4'hA, 4'h5}, cks: 4'h1};
        vt[2] = '{single: 1'b0, addr: 2'd0, stall: 5, poke: 0, n: 4,
                  exp_addr: '{2'd0, 2'd1, 2'd2, 2'd3},
                  exp_data: '{4'hA, 4'h5, 4'h3, 4'hF}, cks: 4'h1};
        vt[3] = '{single: 1'b0, addr: 2'd0, stall: 0, poke: 2, n: 4,
                  exp_addr: '{2'd0, 2'd1, 2'd2, 2'd3},
                  exp_data: '{4'hA, 4'h5, 4'h3, 4'hF}, cks: 4'h1};
        vt[4] = '{single: 1'b1, addr: 2'd0, stall: 0, poke: 0, n: 1,
                  exp_addr: '{2'd0, 2'd0, 2'd0, 2'd0},
                  exp_data: '{4'hA, 4'h0, 4'h0, 4'h0}, cks: 4'hA};

        bus.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("reset_outputs", int'({busy, done, bus.mem_rd_en, bus.out_valid}), 0);
        chk("reset_checksum", int'(checksum), 0);
        @(negedge clk_2) reset_n = 1'b1;
        tick();
        chk("post_reset_idle", int'({busy, done, bus.mem_rd_en, bus.out_valid}), 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vt[i]);
            tick();
        end

        // Asynchronous reset during the second HOLD of a sweep
        single = 1'b0;
        start_addr = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        holds = 0;
        for (int c = 0; c < 20 && holds < 2; c++) begin
            if (bus.out_valid) holds++;
            if (holds < 2) tick();
        end
        chk("rst_reached_hold2", holds, 2);
        chk("rst_pre_valid", int'(bus.out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_rd_en", int'(bus.mem_rd_en), 0);
        chk("rst_checksum", int'(checksum), 0);
        @(negedge clk_2) reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rst_stay_idle%0d", c),
                int'({busy, done, bus.mem_rd_en, bus.out_valid}), 0);
        end
        run_vec(5, vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_sweep_reader.md
# mem_sweep_reader

Read-side master for the switch-programmed 4-entry data memory on the lab board. It issues read requests on the memory's synchronous read port and returns each word with its address over a valid/ready stream to the display logic (LED/SEG/LCD). It can fetch one word or sweep every entry starting from any address, wrapping around the address space.

## Interface
Parameters:
- NBITS_ADDR, 2, memory address width; the memory depth is 1<<NBITS_ADDR.
- NBITS_DATA, 4, memory word width.

Ports:
- clk_2  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transaction; sampled only in IDLE.
- single  in  1  sampled with start: 1 = read one word; 0 = full sweep.
- start_addr  in  NBITS_ADDR  first address; sampled with start.
- mem_rd_en  out  1  read strobe to the memory.
- mem_addr  out  NBITS_ADDR  read address.
- mem_data  in  NBITS_DATA  read data; valid the cycle after mem_rd_en.
- out_valid  out  1  out_addr/out_data hold a word.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  NBITS_ADDR  address of the presented word.
- out_data  out  NBITS_DATA  presented word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transaction ends.
- checksum  out  NBITS_DATA  running sum of the words in the current or last transaction (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE: on start=1, latch single, cur_addr<=start_addr, cnt<=0, checksum<=0, then go to REQ.
- REQ: mem_rd_en=1, mem_addr=cur_addr, then go to WAIT.
- WAIT: capture out_data<=mem_data, out_addr<=cur_addr, then go to HOLD.
- HOLD: out_valid=1; out_addr and out_data stay stable. When out_valid&&out_ready, the transfer happens and checksum<=checksum+out_data (mod 2^NBITS_DATA).
  - If single=1, or cnt is 2^NBITS_ADDR-1, go to DONE.
  - Otherwise cur_addr<=cur_addr+1 (wraps modulo 2^NBITS_ADDR), cnt<=cnt+1, and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- A sweep covers every entry exactly once. For example, start_addr=2 gives the order 2,3,0,1.
- start is ignored outside IDLE; it is not queued.
- mem_rd_en is 0 in every state except REQ; mem_addr holds cur_addr.
- Reset (reset_n=0, asynchronous): the FSM goes to IDLE immediately, and all registers and outputs clear to 0. This applies mid-transaction; no done pulse is produced.
- After reset_n rises, the block needs a new start.

## Timing
- start is seen at posedge k. The next edges produce REQ in cycle k+1, WAIT in k+2 and HOLD in k+3.
- Latency from start to the first out_valid is 3 cycles.
- With out_ready held at 1, each word takes 3 cycles (REQ, WAIT, HOLD).
- A single read therefore runs REQ, WAIT, HOLD, DONE, IDLE: busy is high for 4 cycles and done is high in the 4th.
- A full sweep of 4 entries with out_ready=1 takes 12 cycles plus the DONE cycle.
- Back-pressure: each cycle with out_ready=0 in HOLD adds one cycle. No new mem_rd_en is issued while a word is unaccepted.
- out_valid is never high in IDLE, REQ, WAIT or DONE.
- done and out_valid are never high together.

## Configuration
- MEM_SWEEP_READER_CHECKSUM_EN defined: the checksum register and adder are built.
  - checksum clears when start is accepted and accumulates on each accepted transfer.
  - It holds its value in IDLE until the next start or reset.
- Not defined: checksum is a constant 0 and no accumulation logic is built. All other behaviour is unchanged.

## Test plan
Memory model: a synchronous read port holding {0:A, 1:5, 2:3, 3:F}, with read latency 1.
- Single read: start=1, single=1, start_addr=2, out_ready=1.
  - mem_rd_en is high for exactly one cycle with mem_addr=2.
  - 3 cycles after start, out_valid=1 with out_addr=2, out_data=3.
  - done pulses on the next cycle; busy is high for 4 cycles.
- Full sweep with wrap: start=1, single=0, start_addr=2, out_ready=1.
  - Transfers arrive as (2,3), (3,F), (0,A), (1,5), one every 3 cycles.
  - done pulses once; checksum=1 (0x21 mod 16) with CHECKSUM_EN defined.
- Back-pressure: sweep from 0, with out_ready=0 for 5 cycles at the first HOLD.
  - out_valid stays 1 and out_addr=0, out_data=A stay stable.
  - No mem_rd_en during the stall; the sweep resumes correctly afterwards.
- Start while busy: pulse start=1 with start_addr=3 during the WAIT of a sweep from 0.
  - The sweep order stays 0,1,2,3, with a single done pulse.
- Reset mid-operation: pull reset_n low between clock edges during the second HOLD.
  - out_valid, busy, done, mem_rd_en and checksum go to 0 immediately.
  - After release, the block stays in IDLE with no outputs until a new start.
- Macro off: repeat the full-sweep scenario without MEM_SWEEP_READER_CHECKSUM_EN.
  - The transfers are identical and checksum stays 0 throughout.
